// File: rtl/street_speed_scheduler.sv
// Frame-synchronous speed sequencer for the scrolling street/background tiles.
// Ramps to a per-level target, cruises, brakes to a stop and re-ramps on resume.
module street_speed_scheduler #(
    parameter int BASE_SPEED  = 64,
    parameter int LEVEL_STEP  = 16,
    parameter int MAX_SPEED   = 256,
    parameter int NUM_LEVELS  = 8,
    parameter int RAMP_FRAMES = 8,
    parameter int RAMP_STEP   = 8,
    parameter int BRAKE_STEP  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               startOfLevel,
    input  logic               brake,
    input  logic               resume,
    output logic signed [31:0] levelSpeed,
    output logic [3:0]         level,
    output logic [2:0]         state,
    output logic               moving
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAMP    = 3'd1,
        CRUISE  = 3'd2,
        BRAKE   = 3'd3,
        STOPPED = 3'd4
    } state_t;

    state_t             state_q, state_n;
    logic signed [31:0] speed_q, speed_n;
    logic signed [31:0] target_q, target_n;
    logic [3:0]         level_q, level_n;
    logic [31:0]        frame_q, frame_n;
    logic               started_q, started_n;

    int                 tgt_raw;
    int                 ramp_sum;
    int                 brake_dif;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            speed_q   <= '0;
            target_q  <= '0;
            level_q   <= '0;
            frame_q   <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            speed_q   <= speed_n;
            target_q  <= target_n;
            level_q   <= level_n;
            frame_q   <= frame_n;
            started_q <= started_n;
        end
    end

    // Events are taken in priority order; an event the current state ignores
    // falls through so a lower-priority event in the same clk still applies.
    always_comb begin
        state_n   = state_q;
        speed_n   = speed_q;
        target_n  = target_q;
        level_n   = level_q;
        frame_n   = frame_q;
        started_n = started_q;
        tgt_raw   = 0;
        ramp_sum  = 0;
        brake_dif = 0;

        if (startOfLevel) begin
            if (!started_q) begin
                level_n   = '0;
                started_n = 1'b1;
            end else if (int'(level_q) < NUM_LEVELS - 1) begin
                level_n = level_q + 4'd1;
            end
            tgt_raw  = BASE_SPEED + int'(level_n) * LEVEL_STEP;
            target_n = (tgt_raw > MAX_SPEED) ? MAX_SPEED : tgt_raw;
            speed_n  = '0;
            frame_n  = '0;
            state_n  = RAMP;
        end else if (brake && (state_q == RAMP || state_q == CRUISE)) begin
            state_n = BRAKE;
            frame_n = '0;
        end else if (resume && state_q == STOPPED) begin
            state_n = RAMP;
            frame_n = '0;
        end else if (startOfFrame) begin
            case (state_q)
                RAMP: begin
                    if (frame_q == 32'(RAMP_FRAMES - 1)) begin
                        frame_n  = '0;
                        ramp_sum = speed_q + RAMP_STEP;
                        speed_n  = (ramp_sum > target_q) ? target_q : ramp_sum;
                        if (speed_n == target_q) state_n = CRUISE;
                    end else begin
                        frame_n = frame_q + 32'd1;
                    end
                end
                CRUISE: frame_n = '0;
                BRAKE: begin
                    brake_dif = speed_q - BRAKE_STEP;
                    speed_n   = (brake_dif > 0) ? brake_dif : 0;
                    if (speed_n == 0) state_n = STOPPED;
                end
                default: ;
            endcase
        end
    end

    assign levelSpeed = speed_q;
    assign level      = level_q;
    assign state      = state_q;
    assign moving     = (speed_q != 0);

endmodule

// File: tb/tb_street_speed_scheduler.sv
// Directed bench for street_speed_scheduler: default instance plus a
// MAX_SPEED=70 instance for target clamping.
module tb_street_speed_scheduler;

    localparam int W = 40;
    localparam int ST_IDLE = 0, ST_RAMP = 1, ST_CRUISE = 2, ST_BRAKE = 3, ST_STOPPED = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic               a_sof, a_sol, a_brk, a_res;
    logic signed [31:0] a_speed;
    logic [3:0]         a_level;
    logic [2:0]         a_state;
    logic               a_moving;

    logic               b_sof, b_sol, b_brk, b_res;
    logic signed [31:0] b_speed;
    logic [3:0]         b_level;
    logic [2:0]         b_state;
    logic               b_moving;

    street_speed_scheduler u_dut (
        .clk(clk), .reset(reset),
        .startOfFrame(a_sof), .startOfLevel(a_sol), .brake(a_brk), .resume(a_res),
        .levelSpeed(a_speed), .level(a_level), .state(a_state), .moving(a_moving)
    );

    street_speed_scheduler #(.MAX_SPEED(70)) u_dut70 (
        .clk(clk), .reset(reset),
        .startOfFrame(b_sof), .startOfLevel(b_sol), .brake(b_brk), .resume(b_res),
        .levelSpeed(b_speed), .level(b_level), .state(b_state), .moving(b_moving)
    );

    logic [W-1:0] exp_q[$];
    int cmp_cnt  = 0;
    int fail_cnt = 0;

    function automatic logic [W-1:0] pack_exp(input int spd, input int lvl, input int st);
        logic [31:0] s;
        logic [3:0]  l;
        logic [2:0]  t;
        s = spd;
        l = lvl[3:0];
        t = st[2:0];
        return {s, l, t, (spd != 0)};
    endfunction

    task automatic push_exp(input int spd, input int lvl, input int st);
        exp_q.push_back(pack_exp(spd, lvl, st));
    endtask

    task automatic check(input bit sel_b, input string tag);
        logic [W-1:0] obs;
        logic [W-1:0] exp;
        obs = sel_b ? {b_speed, b_level, b_state, b_moving} : {a_speed, a_level, a_state, a_moving};
        cmp_cnt++;
        if (exp_q.size() == 0) begin
            fail_cnt++;
            $error("FAIL %s: no expected entry queued", tag);
            return;
        end
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed spd=%0d lvl=%0d st=%0d mv=%0b, expected spd=%0d lvl=%0d st=%0d mv=%0b",
                   tag, $signed(obs[39:8]), obs[7:4], obs[3:1], obs[0],
                   $signed(exp[39:8]), exp[7:4], exp[3:1], exp[0]);
        end
    endtask

    // One clk with the given pulses held across a single rising edge.
    task automatic step(input bit sel_b, input bit sof, input bit sol, input bit brk, input bit res);
        @(negedge clk);
        if (sel_b) {b_sof, b_sol, b_brk, b_res} = {sof, sol, brk, res};
        else       {a_sof, a_sol, a_brk, a_res} = {sof, sol, brk, res};
        @(negedge clk);
        {a_sof, a_sol, a_brk, a_res} = 4'b0;
        {b_sof, b_sol, b_brk, b_res} = 4'b0;
    endtask

    task automatic run(input bit sel_b, input bit sof, input bit sol, input bit brk, input bit res,
                       input int n, input int spd, input int lvl, input int st, input string tag);
        push_exp(spd, lvl, st);
        repeat (n) step(sel_b, sof, sol, brk, res);
        check(sel_b, tag);
    endtask

    initial begin
        reset = 1'b1;
        {a_sof, a_sol, a_brk, a_res} = 4'b0;
        {b_sof, b_sol, b_brk, b_res} = 4'b0;
        repeat (2) @(negedge clk);
        push_exp(0, 0, ST_IDLE);
        check(1'b0, "reset_state");
        reset = 1'b0;

        run(0, 0, 1, 0, 0,   1,   0, 0, ST_RAMP,    "first_level");
        run(0, 1, 0, 0, 0,   7,   0, 0, ST_RAMP,    "ramp_before_tick");
        run(0, 1, 0, 0, 0,   1,   8, 0, ST_RAMP,    "ramp_first_tick");
        run(0, 1, 0, 0, 0,  55,  56, 0, ST_RAMP,    "ramp_before_cruise");
        run(0, 1, 0, 0, 0,   1,  64, 0, ST_CRUISE,  "cruise_64");
        run(0, 1, 0, 0, 0,   5,  64, 0, ST_CRUISE,  "cruise_hold");
        run(0, 0, 0, 0, 1,   1,  64, 0, ST_CRUISE,  "resume_ignored_cruise");
        run(0, 0, 0, 1, 0,   1,  64, 0, ST_BRAKE,   "brake_accept");
        run(0, 1, 0, 0, 0,   1,  32, 0, ST_BRAKE,   "brake_frame1");
        run(0, 1, 0, 0, 0,   1,   0, 0, ST_STOPPED, "brake_frame2");
        run(0, 0, 0, 1, 0,   1,   0, 0, ST_STOPPED, "brake_ignored_stopped");
        run(0, 1, 0, 0, 0,   3,   0, 0, ST_STOPPED, "stopped_hold");
        run(0, 0, 0, 0, 1,   1,   0, 0, ST_RAMP,    "resume_accept");
        run(0, 1, 0, 0, 0,   8,   8, 0, ST_RAMP,    "resume_ramp");

        run(0, 0, 1, 1, 0,   1,   0, 1, ST_RAMP,    "level_and_brake");
        run(0, 1, 0, 0, 0,  80,  80, 1, ST_CRUISE,  "cruise_80");
        run(0, 0, 0, 1, 1,   1,  80, 1, ST_BRAKE,   "brake_and_resume");
        run(0, 1, 0, 0, 0,   3,   0, 1, ST_STOPPED, "brake_from_80");
        run(0, 1, 1, 0, 0,   1,   0, 2, ST_RAMP,    "level_and_frame");
        run(0, 1, 0, 0, 0,   7,   0, 2, ST_RAMP,    "frame_not_counted");
        run(0, 1, 0, 0, 0,   1,   8, 2, ST_RAMP,    "tick_after_collision");

        run(0, 0, 1, 0, 0,   2,   0, 4, ST_RAMP,    "level_4");
        run(0, 1, 0, 0, 0, 127, 120, 4, ST_RAMP,    "ramp_l4_before_cruise");
        run(0, 1, 0, 0, 0,   1, 128, 4, ST_CRUISE,  "target_128");
        run(0, 0, 1, 0, 0,  12,   0, 7, ST_RAMP,    "level_saturate");
        run(0, 1, 0, 0, 0, 176, 176, 7, ST_CRUISE,  "target_176");
        run(0, 0, 1, 0, 0,   1,   0, 7, ST_RAMP,    "level_stays_7");
        run(0, 1, 0, 0, 0,  64,  64, 7, ST_RAMP,    "ramp_l7_64");
        run(0, 0, 0, 1, 0,   1,  64, 7, ST_BRAKE,   "brake_in_ramp");
        run(0, 1, 0, 0, 0,   1,  32, 7, ST_BRAKE,   "mid_brake_32");

        // Assert reset between clk edges; outputs must clear before the next edge.
        #2;
        reset = 1'b1;
        #1;
        push_exp(0, 0, ST_IDLE);
        check(1'b0, "async_reset_mid_brake");
        @(negedge clk);
        reset = 1'b0;

        run(0, 1, 0, 0, 0,  10,   0, 0, ST_IDLE,    "idle_hold_frames");
        run(0, 0, 0, 1, 1,   1,   0, 0, ST_IDLE,    "idle_ignores_brake_resume");
        run(0, 0, 1, 0, 0,   1,   0, 0, ST_RAMP,    "level_after_reset");

        run(1, 0, 1, 0, 0,   1,   0, 0, ST_RAMP,    "clamp_inst_level0");
        run(1, 1, 0, 0, 0,  64,  64, 0, ST_CRUISE,  "clamp_inst_cruise64");
        run(1, 0, 1, 0, 0,   1,   0, 1, ST_RAMP,    "clamp_inst_level1");
        run(1, 1, 0, 0, 0,  64,  64, 1, ST_RAMP,    "clamp_inst_ramp64");
        run(1, 1, 0, 0, 0,   8,  70, 1, ST_CRUISE,  "clamp_inst_target70");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
